// File: rtl/dff_chk_pkg.sv
// Shared definitions for the D flip-flop response checker: FSM encoding,
// settle-counter width and the golden next-Q rule.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_HALT   = 2'd3
    } chk_state_e;

    // Settle counter width; SETTLE_CYCLES must fit (0..15).
    localparam int unsigned SETTLE_CNT_W = 4;

    // Next Q of a synchronous flop: RST beats SET beats D.
    function automatic logic next_q(input logic d, input logic set, input logic rst);
        return rst ? 1'b0 : (set ? 1'b1 : d);
    endfunction

endpackage

// File: rtl/dff_response_checker_if.sv
// Observation and result bundle of the flop response checker.
// master: side presenting the flop stimulus/response; slave: the checker.
interface dff_response_checker_if #(
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 en;
    logic                 clr;
    logic                 obs_d;
    logic                 obs_set;
    logic                 obs_rst;
    logic                 obs_q;
    logic                 obs_qn;
    logic                 chk_valid;
    logic                 mismatch;
    logic                 sticky_err;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [1:0]           state;

    modport master (
        output en, clr, obs_d, obs_set, obs_rst, obs_q, obs_qn,
        input  chk_valid, mismatch, sticky_err, err_cnt, state
    );

    modport slave (
        input  en, clr, obs_d, obs_set, obs_rst, obs_q, obs_qn,
        output chk_valid, mismatch, sticky_err, err_cnt, state
    );
endinterface

// File: rtl/dff_ref_model.sv
// Golden model of the flop under test: samples D/SET/RST every edge and
// predicts the Q to be observed one edge later. exp_valid marks that at
// least one sample has been taken since the history was last cleared.
module dff_ref_model
    import dff_chk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr_hist,
    input  logic d,
    input  logic set,
    input  logic rst,
    output logic exp_q,
    output logic exp_valid
);

    logic exp_q_q;
    logic exp_valid_q;

    // Prediction register; clearing history only drops the valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q_q     <= 1'b0;
            exp_valid_q <= 1'b0;
        end else if (clr_hist) begin
            exp_valid_q <= 1'b0;
        end else begin
            exp_q_q     <= next_q(d, set, rst);
            exp_valid_q <= 1'b1;
        end
    end

    assign exp_q     = exp_q_q;
    assign exp_valid = exp_valid_q;

endmodule

// File: rtl/dff_response_checker.sv
// Response checker for a D flip-flop under test. Predicts Q with a golden
// model, compares it (and QN == ~Q) each CHECK cycle, and reports a registered
// valid/mismatch pulse, a sticky error flag and a saturating error counter.
// Optional macro DFF_CHK_ASYNC_MODEL_EN: additionally require Q to follow an
// asserted SET/RST in the same cycle, as an async-set/reset flop would.
module dff_response_checker
    import dff_chk_pkg::*;
#(
    parameter int unsigned ERR_CNT_W     = 8,
    parameter int unsigned SETTLE_CYCLES = 2,    // 0..15
    parameter bit          STOP_ON_ERR   = 1'b0
) (
    input logic                   clk,
    input logic                   rst_n,
    dff_response_checker_if.slave bus
);

    localparam logic [SETTLE_CNT_W-1:0] SettleLast = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    chk_state_e              state_q, state_d;
    logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                    chk_valid_q, mismatch_q, sticky_q;
    logic [ERR_CNT_W-1:0]    err_cnt_q;

    logic exp_q, exp_valid, clr_hist;
    logic in_check, sync_pass, sync_fail, do_cmp, cmp_fail;
`ifdef DFF_CHK_ASYNC_MODEL_EN
    logic async_act, async_pass;
`endif

    dff_ref_model u_ref (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_hist  (clr_hist),
        .d         (bus.obs_d),
        .set       (bus.obs_set),
        .rst       (bus.obs_rst),
        .exp_q     (exp_q),
        .exp_valid (exp_valid)
    );

    // Compare logic; X/Z on Q/QN makes the pass term non-1 and so fails.
    always_comb begin
        in_check  = bus.en && (state_q == ST_CHECK);
        sync_pass = (bus.obs_q == exp_q) && (bus.obs_qn == ~bus.obs_q);
        sync_fail = (sync_pass !== 1'b1);
`ifdef DFF_CHK_ASYNC_MODEL_EN
        async_act  = bus.obs_rst || bus.obs_set;
        async_pass = (bus.obs_q == ~bus.obs_rst) && (bus.obs_qn == ~bus.obs_q);
        do_cmp     = in_check && (exp_valid || async_act);
        cmp_fail   = in_check && ((exp_valid && sync_fail) ||
                                  (async_act && (async_pass !== 1'b1)));
`else
        do_cmp     = in_check && exp_valid;
        cmp_fail   = do_cmp && sync_fail;
`endif
        // History is only built while enabled in SETTLE or CHECK.
        clr_hist = !(bus.en && ((state_q == ST_SETTLE) || (state_q == ST_CHECK)));
    end

    // Next-state: EN low always returns to IDLE; HALT waits for EN low.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    settle_cnt_d = '0;
                    state_d      = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SettleLast) begin
                        state_d = ST_CHECK;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SETTLE_CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (STOP_ON_ERR && cmp_fail) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    // Registered result pulses and error bookkeeping; CLR beats a mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            sticky_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            chk_valid_q <= do_cmp;
            mismatch_q  <= cmp_fail;
            if (bus.clr) begin
                sticky_q  <= 1'b0;
                err_cnt_q <= '0;
            end else if (cmp_fail) begin
                sticky_q <= 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign bus.chk_valid  = chk_valid_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.sticky_err = sticky_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.state      = state_q;

endmodule
